// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron step scheduler: Q12.9 state word
// constants, the per-neuron state payload, the sweep FSM state encoding
// and a saturating adder used by the post-spike u update.
package neuron_pkg;

    localparam int unsigned FRAC_BITS = 9;
    localparam int unsigned W         = 21;

    // Q12.9 constants
    localparam logic signed [W-1:0] V_PEAK  = W'(15360);   // +30.0
    localparam logic signed [W-1:0] V_RESET = W'(-33280);  // -65.0
    localparam logic signed [W-1:0] U_INIT  = W'(-6656);   // -13.0
    localparam logic signed [W-1:0] D_INC   = W'(4096);    // +8.0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2,
        ST_SPK  = 2'd3
    } state_e;

    // One neuron's membrane potential and recovery variable
    typedef struct packed {
        logic signed [W-1:0] v;
        logic signed [W-1:0] u;
    } nstate_t;

    // Signed add in W+1 bits, clamped to the W-bit signed range
    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] sum;
        sum = (W+1)'(a) + (W+1)'(b);
        if (sum[W] != sum[W-1]) begin
            return sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return sum[W-1:0];
    endfunction

endpackage

// File: rtl/neuron_state_ram.sv
// Per-neuron (v, u) storage: NUM_NEURONS x 2W register array.
// Ports: clk/rst_n (async active-low, restores V_RESET/U_INIT),
//        we/waddr/wdata single write port, raddr/rd_data_c async read port.
module neuron_state_ram
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  nstate_t          wdata,
    input  logic [IDX_W-1:0] raddr,
    output nstate_t          rd_data_c
);

    nstate_t mem [NUM_NEURONS];

    // Storage with reset to the resting state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                mem[i] <= '{v: V_RESET, u: U_INIT};
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data_c = mem[raddr];

endmodule

// File: rtl/neuron_step_scheduler.sv
// Time-multiplexes one external Izhikevich update datapath across
// NUM_NEURONS neurons. A tick starts a sweep over neurons 0..N-1: each
// neuron's (v, u) is issued on the dp_* request, the returned (v', u') is
// written back with the threshold/reset rule applied, and spiking neurons
// are reported on the spk_* valid/ready interface.
// Ports: clk, rst_n; tick_i/busy_o/done_o/overrun_o sweep control;
//        cfg_* initial-state write (IDLE only); dp_* datapath handshake;
//        spk_* spike events.
module neuron_step_scheduler
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overrun_o,
    input  logic                    cfg_we_i,
    input  logic [IDX_W-1:0]        cfg_idx_i,
    input  logic signed [W-1:0]     cfg_v_i,
    input  logic signed [W-1:0]     cfg_u_i,
    output logic                    dp_req_o,
    output logic [IDX_W-1:0]        dp_idx_o,
    output logic signed [W-1:0]     dp_v_o,
    output logic signed [W-1:0]     dp_u_o,
    input  logic                    dp_ack_i,
    input  logic signed [W-1:0]     dp_v_i,
    input  logic signed [W-1:0]     dp_u_i,
    output logic                    spk_valid_o,
    output logic [IDX_W-1:0]        spk_idx_o,
    input  logic                    spk_ready_i
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic signed [W-1:0] cap_v_q, cap_u_q;
    logic                cap_spk_q;

    logic                ram_we;
    logic [IDX_W-1:0]    ram_waddr;
    nstate_t             ram_wdata;
    nstate_t             ram_rdata;

    logic                is_last;
    logic                ack_spike;
    logic                busy_d, done_d, overrun_d, dp_req_d, spk_valid_d;
    logic [IDX_W-1:0]    dp_idx_d, spk_idx_d;
    logic signed [W-1:0] dp_v_d, dp_u_d;

    assign is_last   = (idx_q == LAST_IDX);
    assign ack_spike = (dp_v_i >= V_PEAK);

    neuron_state_ram #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (ram_we),
        .waddr     (ram_waddr),
        .wdata     (ram_wdata),
        .raddr     (idx_d),
        .rd_data_c (ram_rdata)
    );

    // FSM state and sweep index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Datapath result capture; the spike decision is taken here so done_o
    // can be registered and still land in the final WB cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_v_q   <= '0;
            cap_u_q   <= '0;
            cap_spk_q <= 1'b0;
        end else if (state_q == ST_REQ && dp_ack_i) begin
            cap_v_q   <= dp_v_i;
            cap_u_q   <= dp_u_i;
            cap_spk_q <= ack_spike;
        end
    end

    // Next state, write-back and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ram_we    = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = '{v: cap_v_q, u: cap_u_q};
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick_i) begin
                    idx_d   = '0;
                    state_d = ST_REQ;
                end else if (cfg_we_i) begin
                    ram_we    = 1'b1;
                    ram_waddr = cfg_idx_i;
                    ram_wdata = '{v: cfg_v_i, u: cfg_u_i};
                end
            end
            ST_REQ: begin
                if (dp_ack_i) begin
                    state_d = ST_WB;
                    done_d  = is_last && !ack_spike;
                end
            end
            ST_WB: begin
                ram_we = 1'b1;
                if (cap_spk_q) begin
                    ram_wdata = '{v: V_RESET, u: sat_add(cap_u_q, D_INC)};
                    state_d   = ST_SPK;
                end else if (is_last) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_SPK: begin
                // Handshake is only known this cycle, so a spike on the last
                // neuron reports done_o in the first IDLE cycle
                if (spk_ready_i) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d      = (state_d != ST_IDLE);
        dp_req_d    = (state_d == ST_REQ);
        dp_idx_d    = dp_req_d ? idx_d : '0;
        dp_v_d      = dp_req_d ? ram_rdata.v : '0;
        dp_u_d      = dp_req_d ? ram_rdata.u : '0;
        spk_valid_d = (state_d == ST_SPK);
        spk_idx_d   = spk_valid_d ? idx_d : '0;
        overrun_d   = overrun_o | (tick_i && (state_q != ST_IDLE));
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            overrun_o   <= 1'b0;
            dp_req_o    <= 1'b0;
            dp_idx_o    <= '0;
            dp_v_o      <= '0;
            dp_u_o      <= '0;
            spk_valid_o <= 1'b0;
            spk_idx_o   <= '0;
        end else begin
            busy_o      <= busy_d;
            done_o      <= done_d;
            overrun_o   <= overrun_d;
            dp_req_o    <= dp_req_d;
            dp_idx_o    <= dp_idx_d;
            dp_v_o      <= dp_v_d;
            dp_u_o      <= dp_u_d;
            spk_valid_o <= spk_valid_d;
            spk_idx_o   <= spk_idx_d;
        end
    end

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// Self-checking bench for neuron_step_scheduler. The bench plays the
// datapath and spike consumer and keeps its own model of every neuron's
// (v, u) as plain integers, updated with the threshold/reset rule.
module tb_neuron_step_scheduler;

    localparam int N      = 4;
    localparam int W      = 21;
    localparam int IDX_W  = 2;
    localparam int VPEAK  = 15360;
    localparam int VRES   = -33280;
    localparam int UINIT  = -6656;
    localparam int DINC   = 4096;
    localparam int SMAX   = 1048575;
    localparam int SMIN   = -1048576;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    tick_i = 1'b0;
    logic                    busy_o, done_o, overrun_o;
    logic                    cfg_we_i = 1'b0;
    logic [IDX_W-1:0]        cfg_idx_i = '0;
    logic signed [W-1:0]     cfg_v_i = '0, cfg_u_i = '0;
    logic                    dp_req_o;
    logic [IDX_W-1:0]        dp_idx_o;
    logic signed [W-1:0]     dp_v_o, dp_u_o;
    logic                    dp_ack_i = 1'b0;
    logic signed [W-1:0]     dp_v_i = '0, dp_u_i = '0;
    logic                    spk_valid_o;
    logic [IDX_W-1:0]        spk_idx_o;
    logic                    spk_ready_i = 1'b0;

    neuron_step_scheduler #(.NUM_NEURONS(N), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_i      (tick_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_v_i     (cfg_v_i),
        .cfg_u_i     (cfg_u_i),
        .dp_req_o    (dp_req_o),
        .dp_idx_o    (dp_idx_o),
        .dp_v_o      (dp_v_o),
        .dp_u_o      (dp_u_o),
        .dp_ack_i    (dp_ack_i),
        .dp_v_i      (dp_v_i),
        .dp_u_i      (dp_u_i),
        .spk_valid_o (spk_valid_o),
        .spk_idx_o   (spk_idx_o),
        .spk_ready_i (spk_ready_i)
    );

    always #5 clk = ~clk;

    // Reference model and per-sweep plan
    int mv[N], mu[N];
    int rv[N], ru[N], dly[N], stall[N];
    bit echo[N];
    int n_cmp = 0, n_fail = 0, cnt = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampw(input int x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    task automatic step();
        @(negedge clk);
        cnt++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = VRES;
            mu[i] = UINIT;
        end
    endtask

    task automatic plan_echo();
        for (int i = 0; i < N; i++) begin
            echo[i]  = 1'b1;
            dly[i]   = 0;
            stall[i] = 0;
        end
    endtask

    task automatic cfg_write(input int idx, input int v, input int u);
        cfg_we_i  = 1'b1;
        cfg_idx_i = IDX_W'(idx);
        cfg_v_i   = W'(v);
        cfg_u_i   = W'(u);
        step();
        cfg_we_i  = 1'b0;
        mv[idx] = v;
        mu[idx] = u;
    endtask

    // One full sweep, checking every request against the model.
    // done_at returns the cycle (counted from the tick edge) where done_o was seen.
    task automatic sweep(input bit poke, output int done_at);
        int  budget;
        bit  spk;
        done_at = -1;
        cnt     = 0;
        tick_i  = 1'b1;
        step();
        tick_i   = 1'b0;
        cfg_we_i = 1'b0;
        chk("busy_start", 32'(busy_o), 1);
        for (int i = 0; i < N; i++) begin
            budget = 0;
            while (dp_req_o !== 1'b1 && budget < 20) begin
                step();
                budget++;
            end
            chk("req_seen", 32'(dp_req_o), 1);
            if (dp_req_o !== 1'b1) return;
            chk("dp_idx", 32'(dp_idx_o), i);
            chk("dp_v", 32'(dp_v_o), mv[i]);
            chk("dp_u", 32'(dp_u_o), mu[i]);
            if (echo[i]) begin
                rv[i] = mv[i];
                ru[i] = mu[i];
            end
            for (int k = 0; k < dly[i]; k++) begin
                if (poke && k == 0) begin
                    tick_i    = 1'b1;
                    cfg_we_i  = 1'b1;
                    cfg_idx_i = 2'd2;
                    cfg_v_i   = W'(777);
                    cfg_u_i   = W'(777);
                end
                step();
                tick_i   = 1'b0;
                cfg_we_i = 1'b0;
                chk("req_hold", 32'(dp_req_o), 1);
                chk("v_hold", 32'(dp_v_o), mv[i]);
                chk("idx_hold", 32'(dp_idx_o), i);
            end
            dp_ack_i = 1'b1;
            dp_v_i   = W'(rv[i]);
            dp_u_i   = W'(ru[i]);
            step();
            dp_ack_i = 1'b0;
            chk("req_drop", 32'(dp_req_o), 0);
            spk = (rv[i] >= VPEAK);
            if (spk) begin
                mv[i] = VRES;
                mu[i] = clampw(ru[i] + DINC);
            end else begin
                mv[i] = rv[i];
                mu[i] = ru[i];
            end
            if (!spk) begin
                chk("spk_none", 32'(spk_valid_o), 0);
                chk("done_wb", 32'(done_o), int'(i == N-1));
                if (i == N-1) done_at = cnt;
            end else begin
                chk("done_wb_spk", 32'(done_o), 0);
                step();
                for (int k = 0; k < stall[i]; k++) begin
                    chk("spk_valid_hold", 32'(spk_valid_o), 1);
                    chk("spk_idx_hold", 32'(spk_idx_o), i);
                    chk("req_in_spk", 32'(dp_req_o), 0);
                    dp_ack_i = 1'b1;          // stray ack, must be ignored
                    dp_v_i   = W'(VPEAK + 5);
                    dp_u_i   = W'(12345);
                    step();
                    dp_ack_i = 1'b0;
                end
                chk("spk_valid", 32'(spk_valid_o), 1);
                chk("spk_idx", 32'(spk_idx_o), i);
                spk_ready_i = 1'b1;
                step();
                spk_ready_i = 1'b0;
                chk("spk_drop", 32'(spk_valid_o), 0);
                if (i == N-1) begin
                    chk("done_spk", 32'(done_o), 1);
                    done_at = cnt;
                end
            end
        end
        step();
        chk("busy_end", 32'(busy_o), 0);
        chk("done_pulse", 32'(done_o), 0);
    endtask

    int d0, d1;

    initial begin
        // 1: reset values, echo sweep reads them back
        rst_n = 1'b0;
        model_reset();
        plan_echo();
        step();
        step();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_overrun", 32'(overrun_o), 0);
        chk("rst_req", 32'(dp_req_o), 0);
        chk("rst_dpv", 32'(dp_v_o), 0);
        chk("rst_dpu", 32'(dp_u_o), 0);
        chk("rst_spk", 32'(spk_valid_o), 0);
        rst_n = 1'b1;
        step();
        sweep(1'b0, d0);
        chk("t1_done_cycles", d0, 2*N);
        chk("t1_overrun", 32'(overrun_o), 0);

        // 2: cfg write then spike exactly at V_PEAK; then V_PEAK-1 and last-neuron spike
        cfg_write(1, 10240, UINIT);
        plan_echo();
        echo[1] = 1'b0; rv[1] = VPEAK; ru[1] = UINIT;
        sweep(1'b0, d0);
        chk("t2_u_model", mu[1], -2560);
        plan_echo();
        echo[1] = 1'b0; rv[1] = VPEAK - 1; ru[1] = 100;
        echo[3] = 1'b0; rv[3] = VPEAK;     ru[3] = UINIT;
        sweep(1'b0, d0);
        // tick and cfg together: tick wins, write dropped
        cfg_we_i = 1'b1; cfg_idx_i = 2'd0; cfg_v_i = W'(1111); cfg_u_i = W'(2222);
        plan_echo();
        sweep(1'b0, d0);
        chk("t2_echo_cycles", d0, 2*N);

        // 3: spike at idx 2, consumer stalls 5 cycles
        plan_echo();
        echo[2] = 1'b0; rv[2] = VPEAK + 100; ru[2] = 0;
        sweep(1'b0, d0);
        plan_echo();
        echo[2] = 1'b0; rv[2] = VPEAK + 100; ru[2] = 0; stall[2] = 5;
        sweep(1'b0, d1);
        chk("t3_stall_delay", d1 - d0, 5);

        // 4: u saturation on spike, strongly negative v stored as is
        plan_echo();
        echo[0] = 1'b0; rv[0] = VPEAK + 50; ru[0] = SMAX - 1000;
        echo[3] = 1'b0; rv[3] = -40960;     ru[3] = -1234;
        sweep(1'b0, d0);
        chk("t4_sat_model", mu[0], SMAX);
        plan_echo();
        sweep(1'b0, d0);

        // 5: ack delayed 3 cycles, tick and cfg while busy
        plan_echo();
        dly[0] = 3;
        sweep(1'b1, d0);
        chk("t5_done_cycles", d0, 2*N + 3);
        chk("t5_overrun", 32'(overrun_o), 1);

        // random datapath responses, ack delays and consumer stalls
        for (int s = 0; s < 8; s++) begin
            plan_echo();
            for (int i = 0; i < N; i++) begin
                echo[i] = 1'b0;
                if ($urandom_range(1, 0) == 1)
                    rv[i] = VPEAK + int'($urandom_range(2000, 0)) - 1000;
                else
                    rv[i] = int'($urandom_range(120000, 0)) - 60000;
                ru[i]    = int'($urandom_range(2097151, 0)) + SMIN;
                dly[i]   = int'($urandom_range(2, 0));
                stall[i] = int'($urandom_range(3, 0));
            end
            sweep(1'b0, d0);
        end
        plan_echo();
        sweep(1'b0, d0);

        // 6: reset while a spike is pending
        cnt = 0;
        tick_i = 1'b1;
        step();
        tick_i   = 1'b0;
        dp_ack_i = 1'b1;
        dp_v_i   = W'(VPEAK);
        dp_u_i   = '0;
        step();
        dp_ack_i = 1'b0;
        step();
        chk("t6_spk_before", 32'(spk_valid_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_spk_rst", 32'(spk_valid_o), 0);
        chk("t6_busy_rst", 32'(busy_o), 0);
        chk("t6_overrun_rst", 32'(overrun_o), 0);
        chk("t6_done_rst", 32'(done_o), 0);
        step();
        rst_n = 1'b1;
        model_reset();
        plan_echo();
        step();
        sweep(1'b0, d0);
        chk("t6_done_cycles", d0, 2*N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_step_scheduler.md
Name: neuron_step_scheduler

Overview:
- Time-multiplexes one shared Izhikevich update datapath across NUM_NEURONS neurons.
- Owns the per-neuron state (v, u) in Q12.9 signed fixed point.
- On each timestep tick it walks neurons 0..NUM_NEURONS-1: issues each neuron's state to the datapath, writes back the result, applies the spike threshold/reset rule, and emits spike events.

Parameters:
- NUM_NEURONS, 4: neurons served; must be >= 1.
- W, 21: state word width, signed Q12.9.
- IDX_W, 2: index width, $clog2(NUM_NEURONS), minimum 1.
- V_PEAK, 15360: spike threshold, +30.0.
- V_RESET, -33280: post-spike v, -65.0; also the reset value of v.
- U_INIT, -6656: reset value of u, -13.0.
- D_INC, 4096: post-spike u increment, +8.0.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tick_i  in  1  start one timestep sweep; sampled only in IDLE.
- busy_o  out  1  high while a sweep is in progress.
- done_o  out  1  one-cycle pulse when a sweep completes.
- overrun_o  out  1  sticky; set when tick_i arrives while busy; cleared only by reset.
- cfg_we_i  in  1  write initial state; honoured only in IDLE.
- cfg_idx_i  in  IDX_W  neuron to write.
- cfg_v_i, cfg_u_i  in  W each  values to write.
- dp_req_o  out  1  request to the datapath; held until ack.
- dp_idx_o  out  IDX_W  neuron under update.
- dp_v_o, dp_u_o  out  W each  current v and u; stable while dp_req_o is high.
- dp_ack_i  in  1  datapath result valid; sampled only while dp_req_o is high.
- dp_v_i, dp_u_i  in  W each  next v' and u' (raw, before the reset rule).
- spk_valid_o  out  1  spike event valid.
- spk_idx_o  out  IDX_W  spiking neuron index.
- spk_ready_i  in  1  spike consumer ready.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset values:
  - all v = V_RESET, all u = U_INIT.
  - FSM = IDLE, index = 0.
  - all outputs 0; dp_v_o and dp_u_o are 0.
- FSM states: IDLE, REQ, WB, SPK.
  - IDLE: if tick_i, then index := 0, go to REQ, busy_o = 1 from the next cycle. Otherwise, if cfg_we_i, write v[cfg_idx_i] and u[cfg_idx_i] that cycle. If tick_i and cfg_we_i are both high, the tick wins and the cfg write is dropped.
  - REQ: dp_req_o = 1, with dp_idx_o, dp_v_o, dp_u_o driven from the state array. On dp_ack_i, capture dp_v_i/dp_u_i and go to WB; dp_req_o drops in the following cycle. No timeout.
  - WB (exactly 1 cycle):
    - If captured v' >= V_PEAK (signed compare): v[idx] := V_RESET and u[idx] := sat(u' + D_INC), then go to SPK.
    - Otherwise v[idx] := v', u[idx] := u', then go to NEXT-decision.
  - SPK: spk_valid_o = 1, spk_idx_o = idx. Hold until spk_ready_i; the transfer occurs on a cycle with valid && ready. Then go to NEXT-decision.
  - NEXT-decision (inline, no extra state): if idx == NUM_NEURONS-1, pulse done_o, busy_o := 0, go to IDLE. Else idx := idx+1, go to REQ.
- Latency per neuron: 1 (REQ, minimum) + ack wait + 1 (WB) + spike stall. A sweep with a zero-wait datapath and no spikes takes 2*NUM_NEURONS cycles, with done_o in the last WB cycle.
- Arithmetic: sat(x) is computed in W+1 bits and clamped to [-2^(W-1), 2^(W-1)-1]. The threshold compare is exactly at V_PEAK: equal counts as a spike. Boundary cases:
  - v' = V_PEAK-1 does not spike.
  - Negative v' never spikes.
- Concurrency and reset:
  - tick_i while busy: ignored, and overrun_o := 1.
  - cfg_we_i while busy: ignored, with no flag.
  - Reset mid-sweep aborts the sweep immediately. State returns to reset values; no done_o and no spike is emitted.
- dp_ack_i outside REQ is ignored.

Decomposition:
- Shared package neuron_pkg holds:
  - Q12.9 constants FRAC_BITS=9, V_PEAK, V_RESET, U_INIT, D_INC.
  - a saturating-add function.
  - the FSM state enum. The datapath and bench reuse these constants.
- One sub-module: neuron_state_ram, an NUM_NEURONS x 2W register array with one write port and one async read port, reset to V_RESET/U_INIT.

Test Plan:
1. Reset, then read via a sweep with an echo datapath (v'=v, u'=u, ack same cycle) → dp_v_o=-33280 and dp_u_o=-6656 for every idx; done_o after 8 cycles; no spikes.
2. cfg neuron 1: v=10240 (20.0). Datapath returns v'=15360, u'=-6656 → spk_valid_o with idx=1; stored v=-33280, u=-2560. Also: v'=15359 → no spike, v stored 15359.
3. spk_ready_i held low for 5 cycles on a spike at idx 2 → spk_valid_o stays 1 and spk_idx_o stays 2; dp_req_o stays 0; sweep resumes after the handshake; done_o is delayed by exactly 5 cycles.
4. u'=1048575-1000 with a spike → u saturates to 1048575. v'=-40960 (-80.0) → no spike, stored as is.
5. Datapath ack delayed 3 cycles → dp_req_o and dp_v_o stay stable for 4 cycles. A tick_i during the sweep sets overrun_o, and the sweep count is unchanged.
6. Drop rst_n mid-SPK → spk_valid_o=0 and busy_o=0 immediately; all state is back to reset values; overrun_o is cleared.
